gmii_tx_framer: RTL and testbench

//  Consumes one buffered frame at a time from the upstream tx-side frame FIFO (valid/ack

---
 rtl/eth_pkg.sv | 26 ++
 rtl/crc32_d8.sv | 34 +++
 rtl/gmii_tx_framer.sv | 149 ++++++++++++++
 tb/tb_gmii_tx_framer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet constants: preamble/SFD bytes, reflected CRC32 parameters and
// the tx framer state encoding.
package eth_pkg;
  localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE        = 8'hD5;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  // Residue in MSB-first form; the reflected register holds its bit reversal.
  localparam logic [31:0] CRC32_RESIDUE   = 32'hC704DD7B;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_PAD  = 3'd3;
  localparam logic [2:0] ST_FCS  = 3'd4;
  localparam logic [2:0] ST_IFG  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_PRE  = ST_PRE,
    S_DATA = ST_DATA,
    S_PAD  = ST_PAD,
    S_FCS  = ST_FCS,
    S_IFG  = ST_IFG
  } tx_state_e;
endpackage

// File: rtl/crc32_d8.sv
// Byte-wide reflected 802.3 CRC32 register; init has priority over en.
// Result of a byte is visible on crc the cycle after it is presented.
module crc32_d8 import eth_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] crc
);
  logic [31:0] crc_q, crc_d;

  function automatic logic [31:0] crc_next(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (init)    crc_d = CRC32_INIT;
    else if (en) crc_d = crc_next(crc_q, din);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= CRC32_INIT;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;
endmodule

// File: rtl/gmii_tx_framer.sv
// Frame FIFO -> GMII: preamble/SFD, zero pad to MIN_LEN, FCS, enforced IFG.
// GMII outputs registered (one cycle behind state); upstream is paced only via in_ack.
module gmii_tx_framer import eth_pkg::*; #(
  parameter int unsigned ACK_LAT = 2,
  parameter int unsigned IFG_LEN = 12,
  parameter int unsigned MIN_LEN = 60
) (
  input  logic        tx_clk,
  input  logic        tx_rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ack,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic [15:0] frame_cnt,
  output logic        busy
);
  localparam logic [10:0] ACK_IDX   = 11'(8 - ACK_LAT);
  localparam logic [10:0] MIN_LEN_C = 11'(MIN_LEN);
  localparam logic [10:0] LEN_MAX   = 11'd2047;
  localparam logic [7:0]  IFG_C     = 8'(IFG_LEN);

  tx_state_e   state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [7:0]  ifg_q, ifg_d;
  logic [7:0]  txd_q, txd_d;
  logic        txen_q, txen_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        crc_init, crc_en;
  logic [7:0]  crc_din;
  logic [31:0] crc;

  crc32_d8 u_crc (
    .clk  (tx_clk),
    .rst  (tx_rst),
    .init (crc_init),
    .en   (crc_en),
    .din  (crc_din),
    .crc  (crc)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ifg_d       = ifg_q;
    txd_d       = 8'h00;
    txen_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    crc_init    = 1'b0;
    crc_en      = 1'b0;
    crc_din     = in_data;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && ifg_q == 8'd0) begin
          state_d = S_PRE;
          cnt_d   = '0;
        end
      end
      S_PRE: begin
        txen_d   = 1'b1;
        txd_d    = (cnt_q == 11'd7) ? SFD_BYTE : PREAMBLE_BYTE;
        crc_init = 1'b1;
        cnt_d    = cnt_q + 11'd1;
        if (cnt_q == 11'd7) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        txen_d = 1'b1;
        if (in_valid) begin
          txd_d  = in_data;
          crc_en = 1'b1;
          cnt_d  = (cnt_q == LEN_MAX) ? cnt_q : cnt_q + 11'd1;
        end else if (cnt_q < MIN_LEN_C) begin
          // The cycle that ends a short payload already carries the first pad byte.
          crc_en  = 1'b1;
          crc_din = 8'h00;
          cnt_d   = cnt_q + 11'd1;
          state_d = S_PAD;
          if (cnt_q + 11'd1 == MIN_LEN_C) begin
            state_d = S_FCS;
            cnt_d   = '0;
          end
        end else begin
          txd_d   = ~crc[7:0];
          state_d = S_FCS;
          cnt_d   = 11'd1;
        end
      end
      S_PAD: begin
        txen_d  = 1'b1;
        crc_en  = 1'b1;
        crc_din = 8'h00;
        cnt_d   = cnt_q + 11'd1;
        if (cnt_q + 11'd1 == MIN_LEN_C) begin
          state_d = S_FCS;
          cnt_d   = '0;
        end
      end
      S_FCS: begin
        txen_d = 1'b1;
        txd_d  = ~crc[{cnt_q[1:0], 3'b000} +: 8];
        cnt_d  = cnt_q + 11'd1;
        if (cnt_q[1:0] == 2'd3) begin
          state_d     = S_IFG;
          cnt_d       = '0;
          ifg_d       = IFG_C;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      S_IFG: begin
        ifg_d = ifg_q - 8'd1;
        if (ifg_q <= 8'd1) begin
          ifg_d   = 8'd0;
          cnt_d   = '0;
          state_d = in_valid ? S_PRE : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ifg_q       <= '0;
      txd_q       <= '0;
      txen_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ifg_q       <= ifg_d;
      txd_q       <= txd_d;
      txen_q      <= txen_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign in_ack     = (state_q == S_PRE) && (cnt_q == ACK_IDX);
  assign busy       = (state_q != S_IDLE);
  assign gmii_txd   = txd_q;
  assign gmii_tx_en = txen_q;
  assign gmii_tx_er = 1'b0;
  assign frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_gmii_tx_framer.sv
// Bench for gmii_tx_framer: table vectors, random frames vs an MSB-first CRC model,
// plus back-to-back gap, mid-frame reset and frame counter wrap sequences.
module tb_gmii_tx_framer;
  localparam int ACK_LAT = 2;
  localparam int IFG_LEN = 12;
  localparam int MIN_LEN = 60;

  logic        tx_clk = 1'b0;
  logic        tx_rst = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ack;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en;
  logic        gmii_tx_er;
  logic [15:0] frame_cnt;
  logic        busy;

  gmii_tx_framer #(.ACK_LAT(ACK_LAT), .IFG_LEN(IFG_LEN), .MIN_LEN(MIN_LEN)) dut (
    .tx_clk     (tx_clk),
    .tx_rst     (tx_rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ack     (in_ack),
    .gmii_txd   (gmii_txd),
    .gmii_tx_en (gmii_tx_en),
    .gmii_tx_er (gmii_tx_er),
    .frame_cnt  (frame_cnt),
    .busy       (busy)
  );

  always #4 tx_clk = ~tx_clk;

  int checks = 0;
  int errors = 0;
  int frames_seen = 0, gap_run = 0, last_gap = 0;
  int frame_acks = 0, last_acks = 0, ack_pos = 0;
  bit in_frame = 1'b0, er_seen = 1'b0, ack_gap = 1'b0;
  logic [7:0] cap_q[$], got_q[$], exp_q[$], pl_q[$];
  logic [15:0] exp_fcnt;

  typedef struct {
    int len;
    int pat;
    int exp_wire;
  } vec_t;
  vec_t vecs[8];

  // Wire monitor: a frame is any contiguous run of gmii_tx_en.
  always @(negedge tx_clk) begin
    if (gmii_tx_er) er_seen = 1'b1;
    if (gmii_tx_en) begin
      if (!in_frame) begin
        cap_q.delete();
        in_frame   = 1'b1;
        last_gap   = gap_run;
        frame_acks = 0;
      end
      cap_q.push_back(gmii_txd);
    end else if (in_frame) begin
      in_frame  = 1'b0;
      got_q     = cap_q;
      last_acks = frame_acks;
      gap_run   = 1;
      frames_seen++;
    end else begin
      gap_run++;
    end
    if (in_ack) begin
      frame_acks++;
      ack_pos = cap_q.size();
      if (!gmii_tx_en) ack_gap = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] b);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = b[31-i];
    return r;
  endfunction

  // Textbook MSB-first CRC32 (poly 0x04C11DB7) over bit-reversed bytes, no final xor.
  function automatic logic [31:0] crc_over(input bit use_got, input int from, input int to_x);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFFFFFF;
    for (int i = from; i < to_x; i++) begin
      b = use_got ? got_q[i] : exp_q[i];
      c = c ^ {rev8(b), 24'h000000};
      for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
    end
    return c;
  endfunction

  task automatic gen_payload(input int len, input int pat);
    pl_q.delete();
    for (int i = 0; i < len; i++)
      pl_q.push_back(pat == 0 ? 8'(i) : 8'($urandom_range(0, 255)));
  endtask

  // Upstream FIFO model: request, optionally drop valid during preamble, then stream
  // pl_q starting ACK_LAT cycles after the ack pulse.
  task automatic drive_frame(input bit drop);
    int w;
    @(negedge tx_clk);
    in_valid = 1'b1;
    if (drop) begin
      w = 0;
      while (!gmii_tx_en && w < 200) begin @(negedge tx_clk); w++; end
      in_valid = 1'b0;
    end
    w = 0;
    while (!in_ack && w < 5000) begin @(negedge tx_clk); w++; end
    if (!in_ack) begin
      chk("ack_timeout", 32'(in_ack), 1);
      in_valid = 1'b0;
      return;
    end
    repeat (ACK_LAT) @(posedge tx_clk);
    #1;
    foreach (pl_q[i]) begin
      in_data  = pl_q[i];
      in_valid = 1'b1;
      @(posedge tx_clk);
      #1;
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(posedge tx_clk);
    #1;
  endtask

  task automatic wait_frames(input int target);
    int w;
    w = 0;
    while (frames_seen < target && w < 4000) begin @(negedge tx_clk); w++; end
    chk("frame_done", frames_seen, target);
  endtask

  task automatic check_frame(input string tag, input int exp_wire);
    logic [31:0] c;
    int mism;
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (pl_q[i]) exp_q.push_back(pl_q[i]);
    while (exp_q.size() < 8 + MIN_LEN) exp_q.push_back(8'h00);
    c = ~rev32(crc_over(1'b0, 8, exp_q.size()));
    for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
    chk({tag, "_len"}, got_q.size(), exp_wire);
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    chk({tag, "_bytes"}, mism, 0);
    chk({tag, "_residue"}, crc_over(1'b1, 8, got_q.size()), 32'hC704DD7B);
    chk({tag, "_acks"}, last_acks, 1);
    chk({tag, "_ackpos"}, ack_pos, 8 - ACK_LAT);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, len, n;
    vecs[0] = '{60,   0, 72};
    vecs[1] = '{10,   0, 72};
    vecs[2] = '{0,    0, 72};
    vecs[3] = '{59,   1, 72};
    vecs[4] = '{61,   1, 73};
    vecs[5] = '{1,    1, 72};
    vecs[6] = '{100,  1, 112};
    vecs[7] = '{1514, 1, 1526};

    #1 tx_rst = 1'b1;
    repeat (3) @(posedge tx_clk);
    #1;
    chk("rst_tx_en", 32'(gmii_tx_en), 0);
    chk("rst_txd", 32'(gmii_txd), 0);
    chk("rst_tx_er", 32'(gmii_tx_er), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ack", 32'(in_ack), 0);
    tx_rst = 1'b0;
    exp_fcnt = 16'd0;
    repeat (2) @(posedge tx_clk);
    #1;

    foreach (vecs[v]) begin
      f0 = frames_seen;
      gen_payload(vecs[v].len, vecs[v].pat);
      drive_frame(1'b0);
      wait_frames(f0 + 1);
      check_frame($sformatf("vec%0d", v), vecs[v].exp_wire);
      exp_fcnt++;
      chk("vec_frame_cnt", 32'(frame_cnt), 32'(exp_fcnt));
    end

    for (int r = 0; r < 6; r++) begin
      f0 = frames_seen;
      len = $urandom_range(0, 140);
      gen_payload(len, 1);
      drive_frame(r[0]);
      wait_frames(f0 + 1);
      check_frame($sformatf("rnd%0d", r), 12 + (len > MIN_LEN ? len : MIN_LEN));
      exp_fcnt++;
      chk("rnd_frame_cnt", 32'(frame_cnt), 32'(exp_fcnt));
    end

    // Two frames queued back to back: the gap must be exactly IFG_LEN.
    f0 = frames_seen;
    gen_payload(20, 0);
    drive_frame(1'b0);
    gen_payload(70, 1);
    drive_frame(1'b0);
    wait_frames(f0 + 2);
    chk("b2b_gap", last_gap, IFG_LEN);
    check_frame("b2b", 82);
    exp_fcnt += 16'd2;
    chk("b2b_frame_cnt", 32'(frame_cnt), 32'(exp_fcnt));

    // Reset while payload byte 30 is being sampled.
    f0 = frames_seen;
    gen_payload(100, 1);
    @(negedge tx_clk);
    in_valid = 1'b1;
    n = 0;
    while (!in_ack && n < 5000) begin @(negedge tx_clk); n++; end
    chk("rst_seq_ack", 32'(in_ack), 1);
    repeat (ACK_LAT) @(posedge tx_clk);
    #1;
    for (int i = 0; i < 30; i++) begin
      in_data = pl_q[i];
      @(posedge tx_clk);
      #1;
    end
    tx_rst = 1'b1;
    #1;
    chk("rst_mid_tx_en", 32'(gmii_tx_en), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    in_data = 8'h00;
    repeat (3) @(posedge tx_clk);
    #1;
    tx_rst = 1'b0;
    chk("rst_trunc_frames", frames_seen, f0 + 1);
    chk("rst_trunc_len", got_q.size(), 37);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    n = 0;
    do begin
      @(posedge tx_clk);
      #1;
      n++;
    end while (!gmii_tx_en && n < 10);
    chk("rst_restart", 32'(n <= 2), 1);
    gen_payload(15, 1);
    drive_frame(1'b0);
    wait_frames(f0 + 2);
    check_frame("rst_next", 72);
    exp_fcnt = 16'd1;
    chk("rst_next_frame_cnt", 32'(frame_cnt), 32'(exp_fcnt));

    // Frame counter wrap.
    @(negedge tx_clk);
    force dut.frame_cnt_q = 16'hFFFE;
    @(negedge tx_clk);
    release dut.frame_cnt_q;
    exp_fcnt = 16'hFFFE;
    for (int w = 0; w < 2; w++) begin
      f0 = frames_seen;
      gen_payload(5 + w, 0);
      drive_frame(1'b0);
      wait_frames(f0 + 1);
      check_frame($sformatf("wrap%0d", w), 72);
      exp_fcnt++;
      chk("wrap_frame_cnt", 32'(frame_cnt), 32'(exp_fcnt));
    end

    chk("tx_er_never_set", 32'(er_seen), 0);
    chk("ack_outside_frame", 32'(ack_gap), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
